ray_frame_scheduler: RTL and testbench
======================================

Name: ray_frame_scheduler

Overview:
Sequences the per-pixel ray tracer across a full frame. On start it walks pixels in raster order and drives the tracer's init/dir bus, one ray at a time. It waits for the tracer's return, with a timeout, and writes the 12-bit shade into the frame buffer. It sits between the top-level display/control logic and the tracer datapath, and also counts collision events per frame.

Parameters:
H_PIX, 160, pixels per row (1..1023)
V_PIX, 120, rows per frame (1..1023)
FOCAL, 11'd256, constant z component of every ray direction
TIMEOUT, 15, max WAIT cycles before forcing a BLACK pixel (1..255)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous active-high reset
start  in  1  begin frame; sampled only in IDLE
cam_pos  in  28  camera origin, passed to tracer init
busy  out  1  high from the cycle after start is accepted until DONE exits
done  out  1  one-cycle pulse at frame end
trace_go  out  1  one-cycle pulse requesting a new ray
init  out  28  ray origin to tracer
dir  out  31  ray direction {x[9:0], y[9:0], FOCAL[10:0]}
tracer_ret  in  1  tracer result valid
tracer_din  in  12  tracer shade (12'h000 black / 12'hFFF white)
collision_sig  in  1  tracer collision flag, valid with tracer_ret
fb_we  out  1  frame-buffer write strobe
fb_addr  out  15  y*H_PIX + x
fb_data  out  12  pixel colour
collision_cnt  out  16  collisions in current/last frame, saturating

Behaviour:
- Reset values:
  - state=IDLE.
  - busy, done, trace_go, fb_we = 0.
  - fb_addr, fb_data, dir x/y fields = 0.
  - collision_cnt = 0; pixel x/y counters = 0; timeout counter = 0.
  - init follows cam_pos combinationally in all states.
- IDLE:
  - If start=1, clear x, y and collision_cnt, set busy=1, go to ISSUE.
  - Otherwise hold.
- ISSUE (1 cycle):
  - Assert trace_go=1; dir = {x, y, FOCAL}, held stable through WAIT.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - If tracer_ret=1, latch tracer_din into fb_data.
    - If collision_sig=1, increment collision_cnt, saturating at 16'hFFFF.
    - Go to WRITE.
  - Else, if the timeout counter reaches TIMEOUT-1, set fb_data=12'h000 (no collision count) and go to WRITE.
  - Else increment the timeout counter.
  - tracer_ret and timeout in the same cycle: tracer_ret wins.
- WRITE (1 cycle):
  - fb_we=1, fb_addr=y*H_PIX+x, fb_data as latched.
  - If x=H_PIX-1 and y=V_PIX-1, go to DONE.
  - Else if x=H_PIX-1, set x=0, y=y+1, go to ISSUE.
  - Else x=x+1, go to ISSUE.
- DONE (1 cycle):
  - done=1, busy=0 on exit; go to IDLE.
  - collision_cnt holds until the next accepted start.
- Throughput and latency:
  - Minimum pixel period is 3 cycles (ISSUE, 1 WAIT cycle, WRITE).
  - tracer_ret is sampled in WAIT only; a ret seen during ISSUE/WRITE/IDLE is ignored.
- Other rules:
  - start while busy is ignored.
  - rst mid-frame: immediate return to reset values next edge; no partial write, fb_we deasserts.
- fb_addr arithmetic:
  - Computed in ≥20 bits, truncated to 15.
  - Parameters must satisfy H_PIX*V_PIX ≤ 32768.
  - fb_addr is incremented, not multiplied; it tracks y*H_PIX+x.

Test Plan:
- Small frame (H_PIX=4, V_PIX=2), tracer model returns ret 2 cycles after trace_go with din=12'hFFF -> exactly 8 fb_we pulses, addresses 0..7 in order, all data 12'hFFF; done pulses once; busy low afterwards.
- Tracer never returns, TIMEOUT=4 -> each pixel written 12'h000 exactly 5 cycles after its trace_go (ISSUE + 4 WAIT); collision_cnt=0.
- Alternate collision_sig=1 on every other ret over the 8-pixel frame -> collision_cnt=4 after done, unchanged until the next start, cleared to 0 on next start.
- Row wrap: on pixel (3,0) → next dir x=0, y=1, fb_addr=4; last pixel (3,1) dir field = {10'd3, 10'd1, FOCAL}.
- Assert start pulses during busy, plus tracer_ret during ISSUE and WRITE -> no restart, no extra writes, still 8 writes total.
- Assert rst in WAIT of pixel 5 -> next cycle all outputs at reset values, no fb_we; a new start rewrites from address 0.

Source files
------------

// File: rtl/ray_frame_scheduler.sv
// ray_frame_scheduler
// Walks every pixel of a frame in raster order and issues one ray per pixel
// to the tracer datapath. It then waits for the tracer result, with a
// timeout that forces a black pixel, and writes the shade to the frame
// buffer. It also counts the collision events reported during the frame.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a frame (only honoured while idle)
//   cam_pos         camera origin, forwarded unchanged on init
//   busy, done      frame in progress / one-cycle end-of-frame pulse
//   trace_go        one-cycle ray request, dir valid with it and held after
//   init, dir       ray origin and direction {x, y, FOCAL}
//   tracer_ret      tracer result valid, with tracer_din and collision_sig
//   fb_we/addr/data frame-buffer write port, address = y*H_PIX + x
//   collision_cnt   saturating collision count for the current/last frame
module ray_frame_scheduler #(
    parameter int          H_PIX   = 160,
    parameter int          V_PIX   = 120,
    parameter logic [10:0] FOCAL   = 11'd256,
    parameter int          TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [27:0] cam_pos,
    output logic        busy,
    output logic        done,
    output logic        trace_go,
    output logic [27:0] init,
    output logic [30:0] dir,
    input  logic        tracer_ret,
    input  logic [11:0] tracer_din,
    input  logic        collision_sig,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [11:0] fb_data,
    output logic [15:0] collision_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [9:0] X_LAST   = 10'(H_PIX - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_PIX - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    // Linear address is kept wider than the port so the running sum never
    // wraps internally; only the low 15 bits leave the block.
    logic [19:0] addr_q, addr_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [9:0]  dir_x_q, dir_x_d;
    logic [9:0]  dir_y_q, dir_y_d;
    logic [11:0] fb_data_q, fb_data_d;
    logic [15:0] coll_q, coll_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        go_q, go_d;
    logic        we_q, we_d;

    logic        row_end_s;
    logic        frame_end_s;
    logic        tmo_hit_s;

    assign row_end_s   = (x_q == X_LAST);
    assign frame_end_s = row_end_s && (y_q == Y_LAST);
    assign tmo_hit_s   = (tmo_q == TMO_LAST);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            addr_q    <= 20'd0;
            tmo_q     <= 8'd0;
            dir_x_q   <= 10'd0;
            dir_y_q   <= 10'd0;
            fb_data_q <= 12'h000;
            coll_q    <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            go_q      <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            tmo_q     <= tmo_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            fb_data_q <= fb_data_d;
            coll_q    <= coll_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            go_q      <= go_d;
            we_q      <= we_d;
        end
    end

    // Next-state logic of the frame sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result in the timeout cycle is still taken as a result.
                if (tracer_ret || tmo_hit_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WRITE: begin
                if (frame_end_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pixel counters, timeout counter, shade latch and collision count.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        tmo_d     = tmo_q;
        fb_data_d = fb_data_q;
        coll_d    = coll_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d    = 10'd0;
                    y_d    = 10'd0;
                    addr_d = 20'd0;
                    coll_d = 16'd0;
                end else begin
                    coll_d = coll_q;
                end
            end
            ST_ISSUE: begin
                tmo_d = 8'd0;
            end
            ST_WAIT: begin
                if (tracer_ret) begin
                    fb_data_d = tracer_din;
                    if (collision_sig && (coll_q != 16'hFFFF)) begin
                        coll_d = coll_q + 16'd1;
                    end else begin
                        coll_d = coll_q;
                    end
                end else if (tmo_hit_s) begin
                    fb_data_d = 12'h000;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_WRITE: begin
                // The address is stepped alongside x/y rather than multiplied.
                if (frame_end_s) begin
                    addr_d = addr_q;
                end else if (row_end_s) begin
                    x_d    = 10'd0;
                    y_d    = y_q + 10'd1;
                    addr_d = addr_q + 20'd1;
                end else begin
                    x_d    = x_q + 10'd1;
                    addr_d = addr_q + 20'd1;
                end
            end
            ST_DONE: begin
                coll_d = coll_q;
            end
            default: begin
                coll_d = coll_q;
            end
        endcase
        // Direction is captured on entry to ISSUE and held until the next ray.
        if (state_d == ST_ISSUE) begin
            dir_x_d = x_d;
            dir_y_d = y_d;
        end else begin
            dir_x_d = dir_x_q;
            dir_y_d = dir_y_q;
        end
    end

    // Output decode from the next state so the strobes come out of flops.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        go_d   = (state_d == ST_ISSUE);
        we_d   = (state_d == ST_WRITE);
        done_d = (state_d == ST_DONE);
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign trace_go      = go_q;
    assign fb_we         = we_q;
    assign fb_addr       = addr_q[14:0];
    assign fb_data       = fb_data_q;
    assign collision_cnt = coll_q;
    assign dir           = {dir_x_q, dir_y_q, FOCAL};
    assign init          = cam_pos;

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Directed bench for ray_frame_scheduler on a 4x2 frame with TIMEOUT=4.
module tb_ray_frame_scheduler;

    localparam int          H   = 4;
    localparam int          V   = 2;
    localparam int          NPX = H * V;
    localparam logic [10:0] FOC = 11'd256;

    logic        clk;
    logic        rst;
    logic        start;
    logic [27:0] cam_pos;
    logic        busy;
    logic        done;
    logic        trace_go;
    logic [27:0] init;
    logic [30:0] dir;
    logic        tracer_ret;
    logic [11:0] tracer_din;
    logic        collision_sig;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [11:0] fb_data;
    logic [15:0] collision_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    // tracer model controls
    int          ret_delay = 0;
    logic [11:0] ret_din   = 12'h000;
    bit          coll_alt  = 1'b0;
    bit          noise     = 1'b0;
    bit          phase     = 1'b0;
    int          pend      = 0;

    // monitor logs
    int          cyc    = 0;
    int          go_cyc = 0;
    int          done_cnt = 0;
    logic [14:0] wr_addr[$];
    logic [11:0] wr_data[$];
    int          wr_lat[$];
    logic [30:0] dir_log[$];

    ray_frame_scheduler #(
        .H_PIX(H), .V_PIX(V), .FOCAL(FOC), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cam_pos(cam_pos),
        .busy(busy), .done(done), .trace_go(trace_go), .init(init), .dir(dir),
        .tracer_ret(tracer_ret), .tracer_din(tracer_din),
        .collision_sig(collision_sig), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_data(fb_data), .collision_cnt(collision_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [30:0] exp_dir(input int i);
        logic [9:0] ex;
        logic [9:0] ey;
        ex = 10'(i % H);
        ey = 10'(i / H);
        return {ex, ey, FOC};
    endfunction

    // Tracer model: answers ret_delay cycles after trace_go (0 = never),
    // and optionally raises a spurious ret during ISSUE and WRITE.
    initial begin
        tracer_ret = 1'b0; tracer_din = 12'h000; collision_sig = 1'b0;
        forever begin
            @(posedge clk); #1;
            tracer_ret = 1'b0; tracer_din = 12'h000; collision_sig = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    tracer_ret    = 1'b1;
                    tracer_din    = ret_din;
                    collision_sig = coll_alt && !phase;
                    phase         = !phase;
                end
            end
            if (trace_go && ret_delay > 0) pend = ret_delay;
            if (noise && (trace_go || fb_we)) begin
                tracer_ret = 1'b1; tracer_din = 12'h5A5; collision_sig = 1'b1;
            end
        end
    end

    // Monitor: logs every ray request and frame-buffer write.
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (trace_go) begin
                go_cyc = cyc;
                dir_log.push_back(dir);
            end
            if (fb_we) begin
                wr_addr.push_back(fb_addr);
                wr_data.push_back(fb_data);
                wr_lat.push_back(cyc - go_cyc);
            end
            if (done) done_cnt++;
        end
    end

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_lat.delete(); dir_log.delete();
        done_cnt = 0;
    endtask

    task automatic run_frame(input bit poke_start);
        bit seen;
        seen = 1'b0;
        clear_logs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'd1);
        check_eq("coll_cleared_on_start", 32'(collision_cnt), 32'd0);
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = poke_start && busy && (k % 3 == 0);
        end
        start = 1'b0;
        check_eq("done_seen", 32'(seen), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("busy_low_after_done", 32'(busy), 32'd0);
        check_eq("done_single_cycle", 32'(done), 32'd0);
    endtask

    task automatic check_frame(input logic [11:0] exp_data, input int exp_lat);
        check_eq("write_count", 32'(wr_addr.size()), 32'(NPX));
        check_eq("ray_count", 32'(dir_log.size()), 32'(NPX));
        check_eq("done_count", 32'(done_cnt), 32'd1);
        for (int i = 0; i < NPX && i < wr_addr.size(); i++) begin
            check_eq($sformatf("wr_addr[%0d]", i), 32'(wr_addr[i]), 32'(i));
            check_eq($sformatf("wr_data[%0d]", i), 32'(wr_data[i]), 32'(exp_data));
            check_eq($sformatf("wr_lat[%0d]", i), 32'(wr_lat[i]), 32'(exp_lat));
        end
        for (int i = 0; i < NPX && i < dir_log.size(); i++) begin
            check_eq($sformatf("dir[%0d]", i), 32'(dir_log[i]), 32'(exp_dir(i)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; cam_pos = 28'hABCDEF1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_trace_go", 32'(trace_go), 32'd0);
        check_eq("rst_fb_we", 32'(fb_we), 32'd0);
        check_eq("rst_fb_addr", 32'(fb_addr), 32'd0);
        check_eq("rst_fb_data", 32'(fb_data), 32'd0);
        check_eq("rst_dir", 32'(dir), 32'(FOC));
        check_eq("rst_coll", 32'(collision_cnt), 32'd0);
        check_eq("init_follows_cam", 32'(init), 32'h0ABCDEF1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Frame 1: result 2 cycles after each request, collision on alternate results.
        ret_delay = 2; ret_din = 12'hFFF; coll_alt = 1'b1; noise = 1'b0; phase = 1'b0;
        run_frame(1'b0);
        check_frame(12'hFFF, 3);
        check_eq("coll_after_frame1", 32'(collision_cnt), 32'd4);
        repeat (10) @(posedge clk);
        #1;
        check_eq("coll_held_idle", 32'(collision_cnt), 32'd4);
        cam_pos = 28'h1234567;
        #1;
        check_eq("init_follows_cam2", 32'(init), 32'h01234567);

        // Frame 2: tracer never answers, spurious rets in ISSUE/WRITE, start pokes while busy.
        ret_delay = 0; coll_alt = 1'b0; noise = 1'b1;
        run_frame(1'b1);
        noise = 1'b0;
        check_frame(12'h000, 5);
        check_eq("coll_after_timeouts", 32'(collision_cnt), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("no_restart_busy", 32'(busy), 32'd0);
        check_eq("no_extra_writes", 32'(wr_addr.size()), 32'(NPX));

        // Frame 3: reset during WAIT of pixel 5, then a clean frame.
        ret_delay = 2; ret_din = 12'hFFF; coll_alt = 1'b0; phase = 1'b0;
        clear_logs();
        found = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (trace_go && dir[30:11] == 20'h00401) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_eq("pixel5_issued", 32'(found), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_fb_we", 32'(fb_we), 32'd0);
        check_eq("midrst_trace_go", 32'(trace_go), 32'd0);
        check_eq("midrst_fb_addr", 32'(fb_addr), 32'd0);
        check_eq("midrst_fb_data", 32'(fb_data), 32'd0);
        check_eq("midrst_dir", 32'(dir), 32'(FOC));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check_eq("midrst_idle_no_we", 32'(fb_we), 32'd0);
        end
        check_eq("midrst_partial_writes", 32'(wr_addr.size()), 32'd5);
        run_frame(1'b0);
        check_frame(12'hFFF, 3);
        check_eq("coll_frame3", 32'(collision_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
